// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register word addresses, edge-capture
// conditions and IRQ source selection.
package pio_pkg;

    localparam logic [2:0] PIO_DATA = 3'd0;
    localparam logic [2:0] PIO_DIR  = 3'd1;
    localparam logic [2:0] PIO_MASK = 3'd2;
    localparam logic [2:0] PIO_EDGE = 3'd3;
    localparam logic [2:0] PIO_SET  = 3'd4;
    localparam logic [2:0] PIO_CLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_input_sync.sv
// Pin input synchroniser with edge detection and a post-reset blanking window
// that hides the artificial 0->1 seen when pins are already high at reset exit.
module pio_input_sync
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int BLANK = SYNC_STAGES + 1;
    localparam int CNT_W = $clog2(BLANK + 1);
    localparam logic [CNT_W-1:0] BLANK_INIT = CNT_W'(BLANK);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] blank_q;
    logic [WIDTH-1:0] edges;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q  <= '0;
            blank_q <= BLANK_INIT;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            if (blank_q != '0) begin
                blank_q <= blank_q - 1'b1;
            end
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edges = ~in_sync & prev_q;
            EDGE_ANY:  edges = in_sync ^ prev_q;
            default:   edges = in_sync & ~prev_q;
        endcase
        edge_pulse = (blank_q == '0) ? edges : '0;
    end

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM slave PIO: data/direction/mask/edge-capture registers with atomic
// set/clear, zero-latency read mux and a registered, maskable interrupt.
module avalon_pio_ext
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_MODE    = IRQ_LEVEL,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] irq_src;
    logic             unused_wd;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             irq_q,  irq_d;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = &{1'b0, writedata};

    pio_input_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    assign irq_src = (IRQ_MODE == IRQ_EDGE) ? edge_q : in_sync;

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        w1c    = '0;
        if (wr) begin
            case (address)
                PIO_DATA: data_d = wd;
                PIO_DIR:  dir_d  = wd;
                PIO_MASK: mask_d = wd;
                PIO_EDGE: w1c    = wd;
                PIO_SET:  data_d = data_q | wd;
                PIO_CLR:  data_d = data_q & ~wd;
                default:  ;
            endcase
        end
        // A new edge in the same cycle as its W1C keeps the bit set.
        edge_d = (edge_q & ~w1c) | edge_pulse;
        irq_d  = |(irq_src & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            dir_q  <= DIR_RESET;
            mask_q <= '0;
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA: readdata[WIDTH-1:0] = (dir_q & data_q) | (~dir_q & in_sync);
            PIO_DIR:  readdata[WIDTH-1:0] = dir_q;
            PIO_MASK: readdata[WIDTH-1:0] = mask_q;
            PIO_EDGE: readdata[WIDTH-1:0] = edge_q;
            default:  readdata = '0;
        endcase
    end

    assign out_port = data_q;
    assign oe       = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed bench for avalon_pio_ext (8 bits, reset value A5, rising edges, edge IRQ,
// 2-stage sync) with a queue-based reference model checked every cycle.
module tb_avalon_pio_ext;

    localparam int         W    = 8;
    localparam int         S    = 2;
    localparam logic [7:0] RV   = 8'hA5;
    localparam logic [7:0] DIRR = 8'hFF;
    localparam int         ET   = 0;
    localparam int         IM   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    avalon_pio_ext #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .DIR_RESET   (DIRR),
        .EDGE_TYPE   (ET),
        .IRQ_MODE    (IM),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins are seen through a pure delay line, edges are judged
    // between consecutive delayed samples, and edges within S+1 clocks of reset are ignored.
    logic [W-1:0] m_data, m_dir, m_mask, m_edge;
    logic         m_irq;
    logic [W-1:0] hist[$];
    int           n_rel;

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[W-1:0] = (m_dir & m_data) | (~m_dir & hist[S-1]);
            3'd1: r[W-1:0] = m_dir;
            3'd2: r[W-1:0] = m_mask;
            3'd3: r[W-1:0] = m_edge;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [W-1:0] cur, prv, ev, clr, wd;
        if (reset) begin
            m_data = RV;
            m_dir  = DIRR;
            m_mask = '0;
            m_edge = '0;
            m_irq  = 1'b0;
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back('0);
            n_rel = 0;
        end else begin
            cur = hist[S-1];
            prv = hist[S];
            if (ET == 1)      ev = ~cur & prv;
            else if (ET == 2) ev = cur ^ prv;
            else              ev = cur & ~prv;
            if (n_rel < S + 1) ev = '0;
            m_irq = |(((IM == 1) ? m_edge : cur) & m_mask);
            clr = '0;
            wd  = writedata[W-1:0];
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = wd;
                    3'd1: m_dir  = wd;
                    3'd2: m_mask = wd;
                    3'd3: clr    = wd;
                    3'd4: m_data = m_data | wd;
                    3'd5: m_data = m_data & ~wd;
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~clr) | ev;
            hist.push_front(in_port);
            void'(hist.pop_back());
            if (n_rel < S + 1) n_rel++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (cmp_en) begin
            check("cyc_out_port", {24'h0, out_port}, {24'h0, m_data});
            check("cyc_oe", {24'h0, oe}, {24'h0, m_dir});
            check("cyc_irq", {31'h0, irq}, {31'h0, m_irq});
            check("cyc_readdata", readdata, model_rd(address));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        check("rst_out_port", {24'h0, out_port}, 32'hA5);
        check("rst_oe", {24'h0, oe}, 32'hFF);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd_chk(3'd0, 32'h0000_00A5, "rst_rd_data");
        rd_chk(3'd2, 32'h0, "rst_rd_mask");
        rd_chk(3'd3, 32'h0, "rst_rd_edge");

        // Data write, atomic set and clear; upper writedata bits ignored
        wr(3'd0, 32'h0000_003C);
        check("wr_data", {24'h0, out_port}, 32'h3C);
        wr(3'd4, 32'h1234_5603);
        check("wr_set", {24'h0, out_port}, 32'h3F);
        wr(3'd5, 32'h0000_0030);
        check("wr_clr", {24'h0, out_port}, 32'h0F);
        rd_chk(3'd4, 32'h0, "rd_set_zero");
        rd_chk(3'd5, 32'h0, "rd_clr_zero");
        rd_chk(3'd6, 32'h0, "rd_rsv_zero");

        // Mixed direction read through the synchroniser
        wr(3'd1, 32'h0F);
        in_port = 8'hF0;
        @(negedge clk);
        rd_chk(3'd0, 32'h0F, "rd_sync_early");
        @(negedge clk);
        rd_chk(3'd0, 32'hFF, "rd_sync");
        @(negedge clk);
        rd_chk(3'd3, 32'hF0, "edge_f0");
        wr(3'd3, 32'hF0);
        rd_chk(3'd3, 32'h0, "edge_w1c");

        // Edge IRQ on bit 0
        wr(3'd2, 32'h01);
        in_port = 8'hF1;
        repeat (3) @(negedge clk);
        rd_chk(3'd3, 32'h01, "edge_bit0");
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_edge", {31'h0, irq}, 32'h1);
        in_port = 8'hF0;
        repeat (4) @(negedge clk);
        rd_chk(3'd3, 32'h01, "edge_no_fall");
        in_port = 8'hF1;
        @(negedge clk);
        wr(3'd3, 32'h01);
        rd_chk(3'd3, 32'h01, "edge_set_wins");
        wr(3'd3, 32'h01);
        rd_chk(3'd3, 32'h0, "edge_cleared");
        check("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_drop", {31'h0, irq}, 32'h0);

        // Pins high through reset: no capture after release
        in_port = 8'hFF;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk(3'd3, 32'h0, "edge_blank");
        rd_chk(3'd0, 32'hA5, "blank_rd_data");

        // Async reset during a SET write with irq high
        wr(3'd0, 32'h12);
        wr(3'd2, 32'h01);
        in_port = 8'hFE;
        repeat (4) @(negedge clk);
        in_port = 8'hFF;
        repeat (4) @(negedge clk);
        check("irq_pre_reset", {31'h0, irq}, 32'h1);
        @(negedge clk);
        address = 3'd4; chipselect = 1'b1; write_n = 1'b0; writedata = 32'hFF;
        #2 reset = 1'b1;
        #1;
        check("async_out_port", {24'h0, out_port}, 32'hA5);
        check("async_irq", {31'h0, irq}, 32'h0);
        check("async_oe", {24'h0, oe}, 32'hFF);
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_out", {24'h0, out_port}, 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
